// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
//   Shared definitions for the iterative multiply/divide unit.
//   - MDOP_* : 5-bit MDOp codes presented on md_op by the EX stage.
//   - md_state_e : sequencer state (IDLE -> CALC -> FIX -> IDLE).
//   - is_muldiv / is_signed_op : opcode classification helpers.
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam logic [4:0] MDOP_NONE  = 5'd0;
    localparam logic [4:0] MDOP_MULT  = 5'd1;
    localparam logic [4:0] MDOP_MULTU = 5'd2;
    localparam logic [4:0] MDOP_DIV   = 5'd3;
    localparam logic [4:0] MDOP_DIVU  = 5'd4;
    localparam logic [4:0] MDOP_MFHI  = 5'd5;
    localparam logic [4:0] MDOP_MFLO  = 5'd6;
    localparam logic [4:0] MDOP_MTHI  = 5'd7;
    localparam logic [4:0] MDOP_MTLO  = 5'd8;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Operations that start the iterative datapath.
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
               (op == MDOP_DIV)  || (op == MDOP_DIVU);
    endfunction

    // Operations that touch HI/LO without computing.
    function automatic logic is_hilo_move(input logic [4:0] op);
        return (op == MDOP_MFHI) || (op == MDOP_MFLO) ||
               (op == MDOP_MTHI) || (op == MDOP_MTLO);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == MDOP_MULT) || (op == MDOP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_md_step.sv
// -----------------------------------------------------------------------------
// md_step
//   Combinational single iteration of the multiply/divide datapath.
//   Ports:
//     div_i  in  1        1 = restoring-divide step, 0 = shift-add multiply step
//     acc_i  in  WIDTH+1  partial product high half (mul) / partial remainder (div)
//     sh_i   in  WIDTH    multiplier/product low half (mul) / dividend->quotient (div)
//     opb_i  in  WIDTH    multiplicand (mul) / divisor (div)
//     acc_o  out WIDTH+1  next acc
//     sh_o   out WIDTH    next shift register
// -----------------------------------------------------------------------------
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] sh_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] sh_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier LSB is set,
        // then shift {acc, sh} right by one; product bits fall into sh.
        sum     = acc_i + (sh_i[0] ? {1'b0, opb_i} : {(WIDTH+1){1'b0}});
        // Divide: shift the next dividend bit into the remainder and trial
        // subtract; one extra bit catches the borrow.
        shifted = {acc_i[WIDTH-1:0], sh_i[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opb_i};

        if (div_i) begin
            if (diff[WIDTH+1]) begin
                acc_o = shifted;
                sh_o  = {sh_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = diff[WIDTH:0];
                sh_o  = {sh_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = {1'b0, sum[WIDTH:1]};
            sh_o  = {sum[0], sh_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative MULT/MULTU/DIV/DIVU engine for the EX stage; owns HI/LO.
//   Ports:
//     clk       in   1      clock, rising edge
//     rstn      in   1      asynchronous active-low reset
//     md_valid  in   1      EX holds a valid muldiv-class instruction
//     md_op     in   5      MDOp code (MDOP_* in muldiv_unit_pkg)
//     md_a      in   WIDTH  rs operand
//     md_b      in   WIDTH  rt operand
//     md_flush  in   1      kill in-flight op
//     md_busy   out  1      state != IDLE
//     md_stall  out  1      pipeline must hold IF/ID/EX this cycle
//     md_done   out  1      pulse in the cycle after HI/LO take a result
//     hi, lo    out  WIDTH  HI/LO registers
//
//   Handshake: an instruction is consumed on a rising edge where md_valid=1
//   and md_stall=0, except a mul/div start, which is consumed on the edge of
//   its own accept cycle (md_stall is high there so EX holds the instruction
//   bits until the unit frees up); a mul/div or HI/LO move seen while busy is
//   simply held by md_stall and re-presented until the unit is IDLE.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             md_valid,
    input  logic [4:0]       md_op,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    input  logic             md_flush,
    output logic             md_busy,
    output logic             md_stall,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             bz_q, bz_d;
    logic             done_q, done_d;

    logic             accept;
    logic             op_signed;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   step_acc;
    logic [WIDTH-1:0] step_sh;

    logic [2*WIDTH-1:0] prod_mag, prod_res;
    logic [WIDTH-1:0]   quo_res, rem_res, res_hi, res_lo;

    md_step #(.WIDTH(WIDTH)) u_step (
        .div_i (is_div_q),
        .acc_i (acc_q),
        .sh_i  (sh_q),
        .opb_i (opb_q),
        .acc_o (step_acc),
        .sh_o  (step_sh)
    );

    assign accept    = (state_q == MD_IDLE) && md_valid && !md_flush && is_muldiv(md_op);
    assign op_signed = is_signed_op(md_op);
    // The core works on magnitudes; signs are re-applied in FIX.
    assign a_mag     = (op_signed && md_a[WIDTH-1]) ? -md_a : md_a;
    assign b_mag     = (op_signed && md_b[WIDTH-1]) ? -md_b : md_b;

    // Result shaping from the finished magnitudes. sa/sb are only ever set
    // for signed ops, so unsigned ops pass through untouched.
    always_comb begin
        prod_mag = {acc_q[WIDTH-1:0], sh_q};
        prod_res = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
        quo_res  = (sa_q ^ sb_q) ? -sh_q : sh_q;
        rem_res  = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        if (is_div_q) begin
            // Divide by zero: the datapath leaves the dividend in the
            // remainder; the quotient is forced to all-ones regardless of sign.
            res_lo = bz_q ? {WIDTH{1'b1}} : quo_res;
            res_hi = rem_res;
        end else begin
            res_hi = prod_res[2*WIDTH-1:WIDTH];
            res_lo = prod_res[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bz_d     = bz_q;
        done_d   = 1'b0;

        unique case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    state_d  = MD_CALC;
                    cnt_d    = '0;
                    acc_d    = '0;
                    sh_d     = a_mag;
                    opb_d    = b_mag;
                    is_div_d = (md_op == MDOP_DIV) || (md_op == MDOP_DIVU);
                    sa_d     = op_signed && md_a[WIDTH-1];
                    sb_d     = op_signed && md_b[WIDTH-1];
                    bz_d     = (md_b == '0);
                end else if (md_valid && !md_flush) begin
                    if (md_op == MDOP_MTHI) hi_d = md_a;
                    if (md_op == MDOP_MTLO) lo_d = md_a;
                end
            end
            MD_CALC: begin
                if (md_flush) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = step_acc;
                    sh_d  = step_sh;
                    if (cnt_q == LAST_CNT) begin
                        state_d = MD_FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (!md_flush) begin
                    hi_d   = res_hi;
                    lo_d   = res_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bz_q     <= bz_d;
            done_q   <= done_d;
        end
    end

    assign md_busy = (state_q != MD_IDLE);
    // Any non-IDLE state already stalls, which also covers HI/LO moves that
    // arrive while busy; the explicit term documents that case. In IDLE only
    // the accept cycle stalls, so a dependent MFHI proceeds right after FIX.
    assign md_stall = accept || md_busy || (md_busy && md_valid && is_hilo_move(md_op));
    assign md_done  = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rstn;
    logic             md_valid;
    logic [4:0]       md_op;
    logic [WIDTH-1:0] md_a;
    logic [WIDTH-1:0] md_b;
    logic             md_flush;
    logic             md_busy;
    logic             md_stall;
    logic             md_done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cur_hi   = 32'd0;
    logic [31:0] cur_lo   = 32'd0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .md_valid (md_valid),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_flush (md_flush),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .md_done  (md_done),
        .hi       (hi),
        .lo       (lo)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit / integer arithmetic.
    function automatic void model(input logic [4:0] op, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      ps;
        logic [63:0] pu;
        int          sa;
        int          sb;
        h = 32'd0;
        l = 32'd0;
        sa = a;
        sb = b;
        case (op)
            MDOP_MULT: begin
                ps = longint'(sa) * longint'(sb);
                {h, l} = ps;
            end
            MDOP_MULTU: begin
                pu = 64'(a) * 64'(b);
                {h, l} = pu;
            end
            MDOP_DIV: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000; h = 32'd0;
                end else begin
                    l = sa / sb; h = sa % sb;
                end
            end
            MDOP_DIVU: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else begin
                    l = a / b; h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = $urandom_range(0, 20);
            4:       v = -$urandom_range(1, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // driver: issue one mul/div from IDLE and check timing and result
    task automatic do_op(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        logic [31:0] eh, el;
        int n_stall, n_busy, n_done;
        model(op, a, b, eh, el);
        @(negedge clk);
        md_valid = 1'b1; md_op = op; md_a = a; md_b = b;
        #1;
        n_stall = md_stall ? 1 : 0;
        n_busy  = 0;
        n_done  = 0;
        @(negedge clk);
        md_valid = 1'b0; md_op = MDOP_NONE;
        for (int i = 0; i < WIDTH + 1; i++) begin
            #1;
            if (md_stall) n_stall++;
            if (md_busy)  n_busy++;
            if (md_done)  n_done++;
            @(negedge clk);
        end
        #1;
        chk({tag, " stall_cycles"}, 32'(n_stall), 32'd34);
        chk({tag, " busy_cycles"},  32'(n_busy),  32'd33);
        chk({tag, " early_done"},   32'(n_done),  32'd0);
        chk({tag, " done"},   32'(md_done),  32'd1);
        chk({tag, " busy"},   32'(md_busy),  32'd0);
        chk({tag, " stall"},  32'(md_stall), 32'd0);
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
        cur_hi = eh;
        cur_lo = el;
    endtask

    logic [4:0] ops [4] = '{MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU};

    initial begin
        logic [31:0] eh, el;
        int          n;
        rstn = 1'b0; md_valid = 1'b0; md_op = MDOP_NONE;
        md_a = '0; md_b = '0; md_flush = 1'b0;
        #12;
        chk("rst busy",  32'(md_busy),  32'd0);
        chk("rst done",  32'(md_done),  32'd0);
        chk("rst stall", 32'(md_stall), 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // directed arithmetic
        do_op(MDOP_MULT,  32'd7,         32'd6,         "mult_7x6");
        do_op(MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        do_op(MDOP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1m1");
        do_op(MDOP_DIV,   32'hFFFF_FFF9, 32'd2,         "div_m7_2");
        do_op(MDOP_DIVU,  32'd7,         32'd0,         "divu_by0");
        do_op(MDOP_DIV,   32'hFFFF_FFF9, 32'd0,         "div_neg_by0");
        do_op(MDOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(MDOP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_min");

        // MTLO / MTHI in IDLE: no stall, visible next edge
        @(negedge clk);
        md_valid = 1'b1; md_op = MDOP_MTLO; md_a = 32'h1234;
        #1 chk("mtlo stall", 32'(md_stall), 32'd0);
        @(negedge clk);
        md_op = MDOP_MTHI; md_a = 32'hCAFE_0001;
        #1 chk("mtlo lo", lo, 32'h1234);
        chk("mtlo done", 32'(md_done), 32'd0);
        @(negedge clk);
        md_valid = 1'b0; md_op = MDOP_NONE;
        #1 chk("mthi hi", hi, 32'hCAFE_0001);
        cur_lo = 32'h1234; cur_hi = 32'hCAFE_0001;

        // unknown op and IDLE flush are ignored
        @(negedge clk);
        md_valid = 1'b1; md_op = 5'h1F; md_a = 32'd9; md_b = 32'd3;
        #1 chk("unk stall", 32'(md_stall), 32'd0);
        @(negedge clk);
        md_op = MDOP_MULT; md_flush = 1'b1;
        #1 chk("unk busy", 32'(md_busy), 32'd0);
        chk("idleflush stall", 32'(md_stall), 32'd0);
        @(negedge clk);
        md_op = MDOP_MTLO; md_a = 32'h5555;
        #1 chk("idleflush busy", 32'(md_busy), 32'd0);
        @(negedge clk);
        md_valid = 1'b0; md_flush = 1'b0; md_op = MDOP_NONE;
        #1 chk("idleflush lo", lo, cur_lo);

        // MFLO issued in cycle 5 of a DIV stalls until the cycle after FIX
        model(MDOP_DIV, 32'd100, 32'hFFFF_FFF9, eh, el);
        @(negedge clk);
        md_valid = 1'b1; md_op = MDOP_DIV; md_a = 32'd100; md_b = 32'hFFFF_FFF9;
        @(negedge clk);
        md_valid = 1'b0; md_op = MDOP_NONE;
        repeat (4) @(negedge clk);
        md_valid = 1'b1; md_op = MDOP_MFLO;
        n = 0;
        for (int i = 0; i < 29; i++) begin
            #1 if (md_stall) n++;
            @(negedge clk);
        end
        #1 chk("mflo stall_cycles", 32'(n), 32'd29);
        chk("mflo stall_after", 32'(md_stall), 32'd0);
        chk("mflo lo", lo, el);
        chk("mflo hi", hi, eh);
        cur_hi = eh; cur_lo = el;
        md_valid = 1'b0; md_op = MDOP_NONE;

        // flush in CALC cycle 10: HI/LO keep old values, no done
        @(negedge clk);
        md_valid = 1'b1; md_op = MDOP_MULTU; md_a = 32'd1000; md_b = 32'd1000;
        @(negedge clk);
        md_valid = 1'b0; md_op = MDOP_NONE;
        repeat (9) @(negedge clk);
        md_flush = 1'b1;
        @(negedge clk);
        md_flush = 1'b0;
        #1 chk("flush busy", 32'(md_busy), 32'd0);
        chk("flush done", 32'(md_done), 32'd0);
        chk("flush hi", hi, cur_hi);
        chk("flush lo", lo, cur_lo);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1 if (md_done) n++;
        end
        chk("flush no_done", 32'(n), 32'd0);

        // held mul/div while busy is accepted in the IDLE cycle after FIX
        @(negedge clk);
        md_valid = 1'b1; md_op = MDOP_MULT; md_a = 32'd7; md_b = 32'd6;
        @(negedge clk);
        md_op = MDOP_DIVU; md_a = 32'd100; md_b = 32'd7;
        n = 0;
        for (int i = 0; i < 33; i++) begin
            #1 if (md_stall) n++;
            @(negedge clk);
        end
        #1 chk("held stall_cycles", 32'(n), 32'd33);
        chk("held first_hi", hi, 32'd0);
        chk("held first_lo", lo, 32'd42);
        chk("held accept_stall", 32'(md_stall), 32'd1);
        @(negedge clk);
        md_valid = 1'b0; md_op = MDOP_NONE;
        #1 chk("held second_busy", 32'(md_busy), 32'd1);
        repeat (33) @(negedge clk);
        #1 chk("held second_done", 32'(md_done), 32'd1);
        chk("held second_lo", lo, 32'd14);
        chk("held second_hi", hi, 32'd2);

        // async reset mid-CALC
        @(negedge clk);
        md_valid = 1'b1; md_op = MDOP_MULT; md_a = 32'd3; md_b = 32'd5;
        @(negedge clk);
        md_valid = 1'b0; md_op = MDOP_NONE;
        repeat (7) @(negedge clk);
        rstn = 1'b0;
        #1 chk("midrst busy", 32'(md_busy), 32'd0);
        chk("midrst hi", hi, 32'd0);
        chk("midrst lo", lo, 32'd0);
        chk("midrst stall", 32'(md_stall), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        do_op(MDOP_MULT, 32'hFFFF_FFFD, 32'd5, "after_rst");

        // randomized ops against the model
        for (int i = 0; i < 20; i++) begin
            do_op(ops[$urandom_range(0, 3)], pick_operand(), pick_operand(), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
